mux_n1_scan: RTL and testbench

- Parametrised N:1 multiplexer with a registered output; the successor to the lab's combinational 2:1 mux.
- Two modes: manual selection from input S, or an auto-scan mode that steps through channels every DWELL cycles, for time-division sampling.
- Used in lab datapaths wherever several W-bit sources share one downstream consumer.

---
 rtl/mux_n1_scan.sv | 119 +++++++++++
 tb/tb_mux_n1_scan.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_n1_scan.sv
// Parametrised N:1 mux with registered output, manual select or auto-scan every DWELL cycles.
// Optional MUX_SCAN_MASK_EN adds a MASK input that removes channels from the auto-scan rotation.
module mux_n1_scan #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DWELL    = 50,
  localparam int unsigned SELW    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [CHANNELS*WIDTH-1:0] A,
  input  logic [SELW-1:0]           S,
  input  logic                      MODE,
  input  logic                      EN,
`ifdef MUX_SCAN_MASK_EN
  input  logic [CHANNELS-1:0]       MASK,
`endif
  output logic [WIDTH-1:0]          Q,
  output logic [SELW-1:0]           CH,
  output logic                      STB
);

  localparam int unsigned       CNTW     = 16;
  localparam logic [SELW:0]     CH_LIM   = (SELW+1)'(CHANNELS);
  localparam logic [CNTW-1:0]   CNT_LAST = CNTW'(DWELL - 1);
`ifndef MUX_SCAN_MASK_EN
  localparam logic [SELW-1:0]   CH_LAST  = SELW'(CHANNELS - 1);
`endif

  logic [WIDTH-1:0] q_q, q_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             stb_q, stb_d;
  logic [SELW-1:0]  nxt_ch;
  logic             s_ok, ch_ok;

  // Unpacked view of the packed channel bus
  logic [WIDTH-1:0] chan [CHANNELS];
  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    assign chan[k] = A[k*WIDTH +: WIDTH];
  end

`ifdef MUX_SCAN_MASK_EN
  logic             all_masked;
  logic             found;
  int unsigned      idx;

  assign all_masked = &MASK;

  // Next unmasked channel in ascending wrapping order; stays put if none other is free
  always_comb begin
    nxt_ch = ch_q;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i < CHANNELS; i++) begin
      idx = 32'(ch_q) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!found && !MASK[idx[SELW-1:0]]) begin
        found  = 1'b1;
        nxt_ch = idx[SELW-1:0];
      end
    end
  end
`else
  assign nxt_ch = (ch_q == CH_LAST) ? '0 : ch_q + SELW'(1);
`endif

  always_comb begin
    q_d   = q_q;
    ch_d  = ch_q;
    cnt_d = cnt_q;
    stb_d = 1'b0;
    s_ok  = {1'b0, S} < CH_LIM;
    ch_ok = {1'b0, ch_q} < CH_LIM;
    if (EN) begin
      if (!MODE) begin
        ch_d  = S;
        cnt_d = '0;
        q_d   = s_ok ? chan[S] : '0;
      end else if (!ch_ok) begin
        // Out-of-range channel carried over from manual mode restarts the scan at 0
        ch_d  = '0;
        cnt_d = '0;
        q_d   = '0;
      end else begin
        q_d = chan[ch_q];
`ifdef MUX_SCAN_MASK_EN
        if (all_masked) q_d = '0;
`endif
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          ch_d  = nxt_ch;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      stb_d = (ch_d != ch_q);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_q   <= '0;
      ch_q  <= '0;
      cnt_q <= '0;
      stb_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ch_q  <= ch_d;
      cnt_q <= cnt_d;
      stb_q <= stb_d;
    end
  end

  assign Q   = q_q;
  assign CH  = ch_q;
  assign STB = stb_q;

endmodule

// File: tb/tb_mux_n1_scan.sv
// Scoreboard bench for mux_n1_scan: two instances (4ch/DWELL=50 and 3ch/DWELL=1) share one
// stimulus stream; a cycle-level reference model predicts Q/CH/STB for each.
module tb_mux_n1_scan;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        EN;
  logic        MODE;
  logic [1:0]  S;
  logic [31:0] A;
  logic [7:0]  q0, q1;
  logic [1:0]  ch0, ch1;
  logic        stb0, stb1;
  logic [3:0]  mask_v = 4'b0000;
`ifdef MUX_SCAN_MASK_EN
  logic [3:0]  MASK;
`endif

  typedef struct { int ch; int cnt; int q; bit stb; } mst_t;
  typedef struct { int q0; int ch0; int stb0; int q1; int ch1; int stb1; } exp_t;

  mst_t m0, m1;
  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  mux_n1_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(50)) u0 (
    .CLK(CLK), .RST_N(RST_N), .A(A), .S(S), .MODE(MODE), .EN(EN),
`ifdef MUX_SCAN_MASK_EN
    .MASK(MASK),
`endif
    .Q(q0), .CH(ch0), .STB(stb0)
  );

  mux_n1_scan #(.WIDTH(8), .CHANNELS(3), .DWELL(1)) u1 (
    .CLK(CLK), .RST_N(RST_N), .A(A[23:0]), .S(S), .MODE(MODE), .EN(EN),
`ifdef MUX_SCAN_MASK_EN
    .MASK(MASK[2:0]),
`endif
    .Q(q1), .CH(ch1), .STB(stb1)
  );

  always #5 CLK = ~CLK;

  function automatic int chan_of(logic [31:0] a, int k);
    return int'((a >> (8 * k)) & 32'hFF);
  endfunction

  function automatic int next_free(int ch, int chans, logic [3:0] msk);
    for (int i = 1; i < chans; i++) begin
      if (!msk[(ch + i) % chans]) return (ch + i) % chans;
    end
    return ch;
  endfunction

  // Reference: state after one clock edge with the given inputs applied
  function automatic mst_t model_step(mst_t m, int chans, int dwell, bit rst, bit en,
                                      bit mode, int s, logic [31:0] a, logic [3:0] msk);
    mst_t r;
    bit   all_m;
    r     = m;
    r.stb = 1'b0;
    if (rst) begin
      r.ch = 0; r.cnt = 0; r.q = 0;
      return r;
    end
    if (!en) return r;
    all_m = 1'b1;
    for (int k = 0; k < chans; k++) if (!msk[k]) all_m = 1'b0;
    if (!mode) begin
      r.ch  = s;
      r.cnt = 0;
      r.q   = (s < chans) ? chan_of(a, s) : 0;
    end else if (m.ch >= chans) begin
      r.ch = 0; r.cnt = 0; r.q = 0;
    end else begin
      r.q   = all_m ? 0 : chan_of(a, m.ch);
      r.cnt = m.cnt + 1;
      if (r.cnt == dwell) begin
        r.cnt = 0;
        r.ch  = next_free(m.ch, chans, msk);
      end
    end
    r.stb = (r.ch != m.ch);
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit en, input bit mode, input int s,
                       input logic [31:0] a);
    @(negedge CLK);
    RST_N = !rst;
    EN    = en;
    MODE  = mode;
    S     = 2'(s);
    A     = a;
`ifdef MUX_SCAN_MASK_EN
    MASK  = mask_v;
`endif
    m0 = model_step(m0, 4, 50, rst, en, mode, s, a, mask_v);
    m1 = model_step(m1, 3, 1, rst, en, mode, s, a, mask_v);
    expq.push_back('{m0.q, m0.ch, int'(m0.stb), m1.q, m1.ch, int'(m1.stb)});
  endtask

  // Monitor: every edge presents a new output word
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("q0",   32'(q0),   32'(e.q0));
        check("ch0",  32'(ch0),  32'(e.ch0));
        check("stb0", 32'(stb0), 32'(e.stb0));
        check("q1",   32'(q1),   32'(e.q1));
        check("ch1",  32'(ch1),  32'(e.ch1));
        check("stb1", 32'(stb1), 32'(e.stb1));
      end
    end
  end

  initial begin
    bit cur_mode;
    int budget;
    RST_N = 1'b0; EN = 1'b0; MODE = 1'b0; S = '0; A = '0;
`ifdef MUX_SCAN_MASK_EN
    MASK = '0;
`endif
    m0 = '{0, 0, 0, 1'b0};
    m1 = '{0, 0, 0, 1'b0};

    repeat (3) drive(1, 0, 0, 0, 32'h0);

    // Manual stepping through every channel
    for (int s = 0; s < 4; s++) drive(0, 1, 0, s, 32'hDDCCBBAA);
    drive(0, 1, 0, 0, 32'hDDCCBBAA);

    // Full auto rotation with wrap, fixed then random data
    repeat (100) drive(0, 1, 1, 0, 32'hDDCCBBAA);
    repeat (110) drive(0, 1, 1, 0, $urandom);

    // EN freeze in the middle of a dwell
    drive(0, 1, 0, 0, 32'hDDCCBBAA);
    repeat (30) drive(0, 1, 1, 0, $urandom);
    repeat (20) drive(0, 0, 1, 0, $urandom);
    repeat (30) drive(0, 1, 1, 0, $urandom);

    // Manual select 2 then auto: scan continues from channel 2
    repeat (10) drive(0, 1, 0, 2, $urandom);
    repeat (60) drive(0, 1, 1, 1, $urandom);

    // Asynchronous reset mid-scan, checked before any clock edge
    repeat (60) drive(0, 1, 1, 0, 32'hDDCCBBAA);
    drive(1, 1, 1, 0, 32'hDDCCBBAA);
    #1;
    check("rst_q0",   32'(q0),   32'h0);
    check("rst_ch0",  32'(ch0),  32'h0);
    check("rst_stb0", 32'(stb0), 32'h0);
    check("rst_ch1",  32'(ch1),  32'h0);
    repeat (2) drive(1, 1, 1, 0, $urandom);
    repeat (60) drive(0, 1, 1, 0, $urandom);

`ifdef MUX_SCAN_MASK_EN
    mask_v = 4'b0110;
    drive(0, 1, 0, 0, $urandom);
    repeat (210) drive(0, 1, 1, 0, $urandom);
    mask_v = 4'b1111;
    repeat (60) drive(0, 1, 1, 0, $urandom);
    repeat (500) begin
      mask_v = 4'($urandom);
      drive(0, $urandom_range(0, 9) != 0, $urandom_range(0, 30) != 0, $urandom, $urandom);
    end
    mask_v = 4'b0000;
`endif

    // Random mix: rare mode flips and resets, mostly enabled
    cur_mode = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 39) == 0) cur_mode = !cur_mode;
      drive($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0, cur_mode,
            int'($urandom_range(0, 3)), $urandom);
    end

    budget = 0;
    while (expq.size() > 0 && budget < 10) begin
      @(posedge CLK);
      budget++;
    end
    #2;
    if (expq.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected outputs never compared", expq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
